// File: rtl/pipeline_hazard_unit_if.sv
// Hazard-unit bundle: pipeline-stage register/control taps in, stall/flush/forward controls out.
// master = pipeline datapath side, slave = hazard unit.
interface pipeline_hazard_unit_if #(
  parameter int REG_AW = 7,
  parameter int CNT_W  = 16
);
  logic [REG_AW-1:0] rs_d, rt_d;
  logic              uses_rs_d, uses_rt_d;
  logic              branch_d, branch_taken_d;
  logic              md_op_d, hilo_rd_d;
  logic [REG_AW-1:0] rs_e, rt_e, wreg_e;
  logic              regwrite_e, memread_e, md_start_e;
  logic [REG_AW-1:0] wreg_m;
  logic              regwrite_m, memread_m;
  logic [REG_AW-1:0] wreg_w;
  logic              regwrite_w;
  logic              mem_busy, exc_req;

  logic              stall_f, stall_d, stall_e, stall_m, stall_w;
  logic              flush_d, flush_e, flush_m, flush_w;
  logic [1:0]        fwd_ad, fwd_bd, fwd_ae, fwd_be;
  logic              md_busy, exc_redirect;
  logic [CNT_W-1:0]  stall_cycles;

  modport master (
    output rs_d, rt_d, uses_rs_d, uses_rt_d, branch_d, branch_taken_d, md_op_d, hilo_rd_d,
           rs_e, rt_e, wreg_e, regwrite_e, memread_e, md_start_e,
           wreg_m, regwrite_m, memread_m, wreg_w, regwrite_w, mem_busy, exc_req,
    input  stall_f, stall_d, stall_e, stall_m, stall_w,
           flush_d, flush_e, flush_m, flush_w,
           fwd_ad, fwd_bd, fwd_ae, fwd_be, md_busy, exc_redirect, stall_cycles
  );

  modport slave (
    input  rs_d, rt_d, uses_rs_d, uses_rt_d, branch_d, branch_taken_d, md_op_d, hilo_rd_d,
           rs_e, rt_e, wreg_e, regwrite_e, memread_e, md_start_e,
           wreg_m, regwrite_m, memread_m, wreg_w, regwrite_w, mem_busy, exc_req,
    output stall_f, stall_d, stall_e, stall_m, stall_w,
           flush_d, flush_e, flush_m, flush_w,
           fwd_ad, fwd_bd, fwd_ae, fwd_be, md_busy, exc_redirect, stall_cycles
  );
endinterface

// File: rtl/pipeline_hazard_unit.sv
// 5-stage pipeline hazard unit: operand forwarding, load-use/branch/mul-div interlocks,
// memory-wait stalls and a precise-exception drain/flush/redirect sequencer.
module pipeline_hazard_unit #(
  parameter int REG_AW     = 7,
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  pipeline_hazard_unit_if.slave hz
);
  localparam int MD_W = (MD_LATENCY > 0) ? $clog2(MD_LATENCY + 1) : 1;

  typedef enum logic [1:0] {IDLE, DRAIN, FLUSH, REDIRECT} exc_state_e;

  exc_state_e       state_q, state_d;
  logic [MD_W-1:0]  md_cnt_q, md_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // forwarding: lanes {rt_e, rs_e, rt_d, rs_d}
  logic [3:0][REG_AW-1:0] fwd_src;
  logic [3:0][1:0]        fwd_sel;

  assign fwd_src = {hz.rt_e, hz.rs_e, hz.rt_d, hz.rs_d};

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      fwd_sel[i] = 2'b00;
      if (!rst && fwd_src[i] != '0) begin
        // a load in M shadows an older W write of the same register
        if (hz.regwrite_m && hz.wreg_m == fwd_src[i])
          fwd_sel[i] = hz.memread_m ? 2'b00 : 2'b01;
        else if (hz.regwrite_w && hz.wreg_w == fwd_src[i])
          fwd_sel[i] = 2'b10;
      end
    end
  end

  assign hz.fwd_ad = fwd_sel[0];
  assign hz.fwd_bd = fwd_sel[1];
  assign hz.fwd_ae = fwd_sel[2];
  assign hz.fwd_be = fwd_sel[3];

  logic d_hit_e, d_hit_m, load_use, branch_haz, md_haz, data_haz, md_busy;

  assign d_hit_e = hz.regwrite_e && hz.wreg_e != '0 &&
                   ((hz.uses_rs_d && hz.rs_d == hz.wreg_e) ||
                    (hz.uses_rt_d && hz.rt_d == hz.wreg_e));
  assign d_hit_m = hz.memread_m && hz.regwrite_m && hz.wreg_m != '0 &&
                   ((hz.uses_rs_d && hz.rs_d == hz.wreg_m) ||
                    (hz.uses_rt_d && hz.rt_d == hz.wreg_m));

  assign load_use   = hz.memread_e && d_hit_e;
  assign branch_haz = hz.branch_d && (d_hit_e || d_hit_m);
  assign md_busy    = md_cnt_q != '0;
  assign md_haz     = md_busy && (hz.md_op_d || hz.hilo_rd_d);
  assign data_haz   = load_use || branch_haz || md_haz;

  // stall = {w,m,e,d,f}, flush = {w,m,e,d}
  logic [4:0] stall;
  logic [3:0] flush;
  logic       redirect;

  always_comb begin
    stall    = '0;
    flush    = '0;
    redirect = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (hz.exc_req || hz.mem_busy) stall = '1;
          else if (data_haz)             begin stall = 5'b00011; flush = 4'b0010; end
          else if (hz.branch_taken_d)    flush = 4'b0001;
        end
        DRAIN:    stall = '1;
        FLUSH:    flush = '1;
        REDIRECT: begin redirect = 1'b1; flush = 4'b0001; end
        default:  ;
      endcase
    end
  end

  assign hz.stall_f      = stall[0];
  assign hz.stall_d      = stall[1];
  assign hz.stall_e      = stall[2];
  assign hz.stall_m      = stall[3];
  assign hz.stall_w      = stall[4];
  assign hz.flush_d      = flush[0];
  assign hz.flush_e      = flush[1];
  assign hz.flush_m      = flush[2];
  assign hz.flush_w      = flush[3];
  assign hz.exc_redirect = redirect;
  assign hz.md_busy      = !rst && md_busy;
  assign hz.stall_cycles = stall_cnt_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (hz.exc_req) state_d = hz.mem_busy ? DRAIN : FLUSH;
      DRAIN:    if (!hz.mem_busy) state_d = FLUSH;
      FLUSH:    state_d = REDIRECT;
      REDIRECT: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    md_cnt_d = md_cnt_q;
    if (state_q == FLUSH)              md_cnt_d = '0;
    else if (hz.md_start_e && !stall[2]) md_cnt_d = MD_W'(MD_LATENCY);
    else if (md_busy)                  md_cnt_d = md_cnt_q - MD_W'(1);
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall[0] && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      md_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Scoreboard bench for pipeline_hazard_unit: stimulus pushes expected outputs from a
// behavioural model; a negedge monitor pops and compares.
module tb_pipeline_hazard_unit;
  localparam int REG_AW = 7, MD_LATENCY = 4, CNT_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipeline_hazard_unit_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) hz ();

  pipeline_hazard_unit #(.REG_AW(REG_AW), .MD_LATENCY(MD_LATENCY), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .hz(hz)
  );

  typedef struct packed {
    logic sf, sd, se, sm, sw;
    logic fd, fe, fm, fw;
    logic [1:0] ad, bd, ae, be;
    logic busy, redir;
    logic [15:0] scnt;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0, errors = 0;

  // behavioural model state
  string phase = "idle";
  int    md_left = 0;
  int    stalls  = 0;

  function automatic logic [1:0] fwd(input logic [REG_AW-1:0] r);
    if (r == 0) return 2'b00;
    if (hz.regwrite_m && hz.wreg_m == r) return hz.memread_m ? 2'b00 : 2'b01;
    if (hz.regwrite_w && hz.wreg_w == r) return 2'b10;
    return 2'b00;
  endfunction

  function automatic bit reads(input logic [REG_AW-1:0] r);
    return r != 0 && ((hz.uses_rs_d && hz.rs_d == r) || (hz.uses_rt_d && hz.rt_d == r));
  endfunction

  function automatic obs_t model();
    obs_t e = '0;
    bit hazard;
    e.scnt = 16'(stalls);
    if (rst) return e;
    e.ad = fwd(hz.rs_d); e.bd = fwd(hz.rt_d);
    e.ae = fwd(hz.rs_e); e.be = fwd(hz.rt_e);
    e.busy = md_left > 0;
    hazard = (hz.memread_e && hz.regwrite_e && reads(hz.wreg_e))
          || (hz.branch_d && ((hz.regwrite_e && reads(hz.wreg_e))
                              || (hz.memread_m && hz.regwrite_m && reads(hz.wreg_m))))
          || (md_left > 0 && (hz.md_op_d || hz.hilo_rd_d));
    if (phase == "drain" || (phase == "idle" && (hz.exc_req || hz.mem_busy)))
      {e.sf, e.sd, e.se, e.sm, e.sw} = '1;
    else if (phase == "flush")
      {e.fd, e.fe, e.fm, e.fw} = '1;
    else if (phase == "redirect") begin
      e.redir = 1; e.fd = 1;
    end else if (hazard) begin
      e.sf = 1; e.sd = 1; e.fe = 1;
    end else if (hz.branch_taken_d)
      e.fd = 1;
    return e;
  endfunction

  task automatic advance(input obs_t e);
    if (rst) begin
      phase = "idle"; md_left = 0; stalls = 0;
    end else begin
      if (e.sf && stalls < 65535) stalls++;
      if (phase == "flush") md_left = 0;
      else if (hz.md_start_e && !e.se) md_left = MD_LATENCY;
      else if (md_left > 0) md_left--;
      case (phase)
        "idle":     if (hz.exc_req) phase = hz.mem_busy ? "drain" : "flush";
        "drain":    if (!hz.mem_busy) phase = "flush";
        "flush":    phase = "redirect";
        default:    phase = "idle";
      endcase
    end
  endtask

  task automatic cycle();
    obs_t e;
    e = model();
    exp_q.push_back(e);
    @(posedge clk);
    advance(e);
    #1;
  endtask

  task automatic clr();
    hz.rs_d = 0; hz.rt_d = 0; hz.uses_rs_d = 0; hz.uses_rt_d = 0;
    hz.branch_d = 0; hz.branch_taken_d = 0; hz.md_op_d = 0; hz.hilo_rd_d = 0;
    hz.rs_e = 0; hz.rt_e = 0; hz.wreg_e = 0;
    hz.regwrite_e = 0; hz.memread_e = 0; hz.md_start_e = 0;
    hz.wreg_m = 0; hz.regwrite_m = 0; hz.memread_m = 0;
    hz.wreg_w = 0; hz.regwrite_w = 0; hz.mem_busy = 0; hz.exc_req = 0;
  endtask

  function automatic logic [REG_AW-1:0] rreg();
    return REG_AW'($urandom_range(0, 3));
  endfunction

  task automatic rand_inputs();
    hz.rs_d = rreg(); hz.rt_d = rreg(); hz.rs_e = rreg(); hz.rt_e = rreg();
    hz.wreg_e = rreg(); hz.wreg_m = rreg(); hz.wreg_w = rreg();
    hz.uses_rs_d = 1'($urandom); hz.uses_rt_d = 1'($urandom);
    hz.branch_d = 1'($urandom); hz.branch_taken_d = 1'($urandom);
    hz.md_op_d = ($urandom_range(0, 3) == 0); hz.hilo_rd_d = ($urandom_range(0, 3) == 0);
    hz.regwrite_e = 1'($urandom); hz.memread_e = 1'($urandom);
    hz.md_start_e = ($urandom_range(0, 5) == 0);
    hz.regwrite_m = 1'($urandom); hz.memread_m = 1'($urandom);
    hz.regwrite_w = 1'($urandom);
    hz.mem_busy = ($urandom_range(0, 5) == 0);
    hz.exc_req = ($urandom_range(0, 15) == 0);
    rst = ($urandom_range(0, 199) == 0);
  endtask

  // monitor
  initial begin
    obs_t e, got;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        got = {hz.stall_f, hz.stall_d, hz.stall_e, hz.stall_m, hz.stall_w,
               hz.flush_d, hz.flush_e, hz.flush_m, hz.flush_w,
               hz.fwd_ad, hz.fwd_bd, hz.fwd_ae, hz.fwd_be,
               hz.md_busy, hz.exc_redirect, hz.stall_cycles};
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL hazard_outputs @%0t: got stall=%b flush=%b fwd=%b busy=%b redir=%b cnt=%0d, expected stall=%b flush=%b fwd=%b busy=%b redir=%b cnt=%0d",
                   $time, {got.sf, got.sd, got.se, got.sm, got.sw}, {got.fd, got.fe, got.fm, got.fw},
                   {got.ad, got.bd, got.ae, got.be}, got.busy, got.redir, got.scnt,
                   {e.sf, e.sd, e.se, e.sm, e.sw}, {e.fd, e.fe, e.fm, e.fw},
                   {e.ad, e.bd, e.ae, e.be}, e.busy, e.redir, e.scnt);
        end
      end
    end
  end

  // stimulus
  initial begin
    clr();
    rst = 1;
    @(posedge clk); #1;
    cycle(); cycle();
    rst = 0;

    // load-use on $5, then the load moves to M and W
    clr(); hz.memread_e = 1; hz.regwrite_e = 1; hz.wreg_e = 5; hz.rs_d = 5; hz.uses_rs_d = 1; cycle();
    clr(); hz.rs_e = 5; hz.rs_d = 5; hz.uses_rs_d = 1; hz.wreg_m = 5; hz.regwrite_m = 1; hz.memread_m = 1; cycle();
    clr(); hz.rs_e = 5; hz.wreg_w = 5; hz.regwrite_w = 1; cycle();

    // M priority over W; $0 never forwarded
    clr(); hz.rs_e = 3; hz.wreg_m = 3; hz.regwrite_m = 1; hz.wreg_w = 3; hz.regwrite_w = 1; cycle();
    clr(); hz.rs_e = 0; hz.wreg_m = 0; hz.regwrite_m = 1; cycle();

    // mul/div then mfhi waits out the latency
    clr(); hz.md_start_e = 1; cycle();
    clr(); hz.hilo_rd_d = 1; repeat (MD_LATENCY + 1) cycle();

    // exception while memory is busy for three cycles
    clr(); hz.exc_req = 1; hz.mem_busy = 1; cycle();
    hz.exc_req = 0; cycle(); cycle();
    hz.mem_busy = 0; repeat (4) cycle();

    // branch with operand in flight, then taken
    clr(); hz.branch_d = 1; hz.branch_taken_d = 1; hz.rs_d = 7; hz.uses_rs_d = 1;
    hz.wreg_e = 7; hz.regwrite_e = 1; cycle();
    hz.regwrite_e = 0; cycle();

    // reset in the middle of DRAIN and of a mul/div
    clr(); hz.exc_req = 1; hz.mem_busy = 1; cycle();
    hz.exc_req = 0; hz.md_start_e = 0; cycle();
    rst = 1; cycle();
    rst = 0; hz.mem_busy = 0; cycle();
    hz.md_start_e = 1; cycle();
    hz.md_start_e = 0; cycle();
    rst = 1; cycle();
    rst = 0; hz.md_op_d = 1; cycle(); cycle();

    // randomized traffic
    repeat (3000) begin
      rand_inputs();
      cycle();
    end

    // counter saturation under continuous memory stall
    clr(); rst = 0; hz.mem_busy = 1;
    repeat (65545) cycle();
    hz.mem_busy = 0; cycle(); cycle();

    @(negedge clk); #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
